// File: rtl/if_fetch_if.sv
// if_fetch_if: byte-wide instruction memory read port (request/address out, data/ack back).
interface if_fetch_if #(parameter int ADDR_WIDTH = 32);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_data;
    logic                  mem_ack;
    modport master (output mem_req, mem_addr, input mem_data, mem_ack);
    modport slave  (input mem_req, mem_addr, output mem_data, mem_ack);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: assembles a 32-bit little-endian instruction from byte reads and owns the IF/ID register.
module if_fetch #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ce_i,
    input  logic [5:0]            stall,
    input  logic                  branch_flag_i,
    if_fetch_if.master            mem,
    output logic                  stallreq_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [31:0]           if_inst_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           buf_q, buf_d, if_inst_d;
    logic [ADDR_WIDTH-1:0] if_pc_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            buf_q     <= 32'd0;
            if_pc_o   <= '0;
            if_inst_o <= NOP_INST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            if_pc_o   <= if_pc_d;
            if_inst_o <= if_inst_d;
        end
    end
    // A taken branch discards the partial word; the byte acked in that cycle is dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        if_pc_d   = if_pc_o;
        if_inst_d = if_inst_o;
        if (branch_flag_i) begin
            state_d = ce_i ? S_REQ : S_IDLE;
            cnt_d   = 2'd0;
            if (!stall[1]) begin
                if_pc_d   = '0;
                if_inst_d = NOP_INST;
            end
        end else begin
            case (state_q)
                S_IDLE: if (ce_i) begin
                    state_d = S_REQ;
                    cnt_d   = 2'd0;
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        buf_d[{cnt_q, 3'b000} +: 8] = mem.mem_data;
                        cnt_d = cnt_q + 2'd1;
                        state_d = (cnt_q == 2'd3) ? S_DONE : S_REQ;
                    end
                    if (!stall[1]) begin
                        if_pc_d   = '0;
                        if_inst_d = NOP_INST;
                    end
                end
                S_DONE: if (!stall[1]) begin
                    state_d   = S_REQ;
                    cnt_d     = 2'd0;
                    if_pc_d   = pc_i;
                    if_inst_d = buf_q;
                end
                default: state_d = S_IDLE;
            endcase
            if (!ce_i) begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        end
    end
    always_comb begin
        mem.mem_req  = (state_q == S_REQ) & ~branch_flag_i;
        mem.mem_addr = pc_i + ADDR_WIDTH'(cnt_q);
        stallreq_o   = ce_i & (state_q != S_DONE) & ~branch_flag_i;
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized and directed checks of if_fetch against a byte-count reference model.
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h00000013;
    logic        clk = 1'b0;
    logic        rst, ce, br, stallreq;
    logic [31:0] pc, if_pc, if_inst;
    logic [5:0]  stall;
    if_fetch_if #(.ADDR_WIDTH(32)) bus();
    if_fetch #(.ADDR_WIDTH(32), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce), .stall(stall),
        .branch_flag_i(br), .mem(bus), .stallreq_o(stallreq),
        .if_pc_o(if_pc), .if_inst_o(if_inst)
    );
    always #5 clk = ~clk;
    function automatic logic [7:0] mb(input logic [31:0] a);
        case (a)
            32'h0:                               return 8'h13;
            32'h40:                              return 8'h93;
            32'h42:                              return 8'h10;
            32'h1, 32'h2, 32'h3, 32'h41, 32'h43: return 8'h00;
            default:                             return 8'((a * 37) ^ (a >> 11));
        endcase
    endfunction
    function automatic logic [31:0] word(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction
    assign bus.mem_data = mb(bus.mem_addr);
    // Model: ph = -1 idle, 0..3 bytes collected so far, 4 = word complete.
    int          ph = -1, wcnt = 0, ack_delay = 0, n_chk = 0, n_fail = 0, n;
    logic [31:0] m_pc = 32'd0, m_inst = NOP;
    bit          obs_stall, obs_req, chk_en = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step(input bit r, input bit c, input bit s1, input bit b, input logic [31:0] p);
        bit inreq, a;
        rst = r; ce = c; pc = p; br = b;
        stall = {4'($urandom), s1, 1'($urandom)};
        inreq = ph >= 0 && ph < 4;
        a = 1'b0;
        if (inreq) begin
            a = (ack_delay < 0) ? 1'($urandom) : (wcnt >= ack_delay);
            wcnt = a ? 0 : wcnt + 1;
        end else wcnt = 0;
        bus.mem_ack = a;
        #1;
        obs_stall = stallreq;
        obs_req = bus.mem_req;
        if (chk_en) begin
            chk("stallreq", 32'(stallreq), 32'(c && ph != 4 && !b));
            chk("mem_req", 32'(bus.mem_req), 32'(inreq && !b));
            if (inreq) chk("mem_addr", bus.mem_addr, p + 32'(ph));
            chk("if_pc", if_pc, m_pc);
            chk("if_inst", if_inst, m_inst);
        end
        if (r) begin
            ph = -1; m_pc = 32'd0; m_inst = NOP;
        end else if (b) begin
            ph = c ? 0 : -1;
            if (!s1) begin m_pc = 32'd0; m_inst = NOP; end
        end else begin
            if (ph < 0) ph = 0;
            else if (ph < 4) begin
                if (a) ph++;
                if (!s1) begin m_pc = 32'd0; m_inst = NOP; end
            end else if (!s1) begin
                m_pc = p; m_inst = word(p); ph = 0;
            end
            if (!c) ph = -1;
        end
        chk_en = 1;
        @(negedge clk);
    endtask
    // Runs one fetch at p to completion and counts cycles with stallreq high.
    task automatic fetch(input logic [31:0] p, input int hold, output int cnt);
        int h;
        bit s1;
        h = hold;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            s1 = (ph == 4 && h > 0);
            if (s1) h--;
            step(1'b0, 1'b1, s1, 1'b0, p);
            if (s1) chk("hold_req", 32'(obs_req), 32'd0);
            else if (obs_stall) cnt++;
            else return;
        end
        n_fail++;
        $display("FAIL fetch_timeout: no completion at pc %h", p);
    endtask
    initial begin
        logic [31:0] p;
        bit r, b, s1, c, chg;
        rst = 1'b1; ce = 1'b0; br = 1'b0; pc = 32'd0; stall = 6'd0; bus.mem_ack = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_stall", 32'(stallreq), 32'd0);
        ack_delay = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        fetch(32'd0, 0, n);
        chk("t1_lat", 32'(n), 32'd4);
        chk("t1_inst", if_inst, 32'h00000013);
        chk("t1_pc", if_pc, 32'd0);
        fetch(32'h40, 0, n);
        chk("t2_lat", 32'(n), 32'd4);
        chk("t2_inst", if_inst, 32'h00100093);
        chk("t2_pc", if_pc, 32'h40);
        ack_delay = 3;
        fetch(32'h100, 0, n);
        chk("t3_lat", 32'(n), 32'd16);
        chk("t3_pc", if_pc, 32'h100);
        ack_delay = 0;
        fetch(32'h200, 3, n);
        chk("t4_lat", 32'(n), 32'd4);
        chk("t4_pc", if_pc, 32'h200);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        chk("t5_stall", 32'(obs_stall), 32'd0);
        chk("t5_req", 32'(obs_req), 32'd0);
        chk("t5_pc", if_pc, 32'd0);
        chk("t5_inst", if_inst, NOP);
        br = 1'b0; pc = 32'h500;
        #1;
        chk("t5_addr", bus.mem_addr, 32'h500);
        fetch(32'h500, 0, n);
        chk("t5_lat", 32'(n), 32'd4);
        chk("t5_tpc", if_pc, 32'h500);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h600);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h600);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h600);
        rst = 1'b0; ce = 1'b0;
        #1;
        chk("t6_req", 32'(bus.mem_req), 32'd0);
        chk("t6_inst", if_inst, NOP);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h600);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h600);
        chk("t6_addr", bus.mem_addr, 32'h600);
        chk("t6_req1", 32'(bus.mem_req), 32'd1);
        fetch(32'h600, 0, n);
        chk("t6_lat", 32'(n), 32'd4);
        fetch(32'hFFFFFFFE, 0, n);
        chk("wrap_pc", if_pc, 32'hFFFFFFFE);
        ack_delay = -1;
        p = $urandom;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 300) == 0;
            b = ($urandom % 12) == 0;
            s1 = ($urandom % 4) == 0;
            c = (ph == 4) ? 1'b1 : (($urandom % 25) != 0);
            chg = r || b || ph < 0 || (ph == 4 && !s1);
            step(r, c, s1, b, p);
            if (chg) p = (($urandom % 8) == 0) ? 32'hFFFFFFFC + 32'($urandom % 4) : $urandom;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
